// File: rtl/rx_crc_checker.sv
// rtl/rx_crc_checker.sv - per-lane receive word CRC-4 checker and RAM writer
// Latches a received word, divides its 14-bit codeword bit-serially, and writes passing words to the lane's RAM region.
module rx_crc_checker #(
  parameter logic [13:0] POLY      = 14'b10111000000000,
  parameter logic [4:0]  ADDR_INIT = 5'b00000,
  parameter int          MSG_LEN   = 10,
  parameter int          CRC_LEN   = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] datain_i,
  input  logic        data_valid_i,
  input  logic        clr_alert_i,
  output logic        in_ready_o,
  output logic        wr_en_o,
  output logic [4:0]  wr_addr_o,
  output logic [15:0] wr_data_o,
  output logic        crc_err_o,
  output logic        frame_done_o,
  output logic [7:0]  err_cnt_o,
  output logic        led_alert_o,
  output logic        overrun_o
);

  localparam int CNT_W = $clog2(MSG_LEN);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_WRITE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [13:0]        w_q, w_d;
  logic [15:0]        word_q, word_d;
  logic               in_ready_q, in_ready_d;
  logic               wr_en_q, wr_en_d;
  logic [4:0]         wr_addr_q, wr_addr_d;
  logic               crc_err_q, crc_err_d;
  logic               frame_done_q, frame_done_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic               led_alert_q, led_alert_d;
  logic               overrun_q, overrun_d;

  logic               accept;
  logic               last_step;
  logic [13:0]        w_step;
  logic               rem_zero;

  assign accept    = (state_q == ST_IDLE) && data_valid_i && datain_i[15];
  assign last_step = (state_q == ST_DIVIDE) && (cnt_q == CNT_W'(MSG_LEN - 1));
  assign w_step    = w_q[13] ? ((w_q ^ POLY) << 1) : (w_q << 1);
  // After the final shift the remainder sits left-aligned in the top CRC_LEN bits.
  assign rem_zero  = (w_step[13 -: CRC_LEN] == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      w_q          <= '0;
      word_q       <= '0;
      in_ready_q   <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= ADDR_INIT;
      crc_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_cnt_q    <= '0;
      led_alert_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      w_q          <= w_d;
      word_q       <= word_d;
      in_ready_q   <= in_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      crc_err_q    <= crc_err_d;
      frame_done_q <= frame_done_d;
      err_cnt_q    <= err_cnt_d;
      led_alert_q  <= led_alert_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_DIVIDE;
      ST_DIVIDE: if (last_step) state_d = ST_WRITE;
      ST_WRITE:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    w_d          = w_q;
    word_d       = word_q;
    wr_addr_d    = wr_addr_q;
    err_cnt_d    = err_cnt_q;
    led_alert_d  = led_alert_q;
    overrun_d    = overrun_q;

    if (accept) begin
      word_d = datain_i;
      w_d    = datain_i[13:0];
      cnt_d  = '0;
    end else if (state_q == ST_DIVIDE) begin
      w_d   = w_step;
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Pulses are registered one edge early so they coincide with the WRITE cycle.
    wr_en_d      = last_step && rem_zero;
    crc_err_d    = last_step && !rem_zero;
    frame_done_d = last_step && word_q[14];

    if (crc_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;

    if (crc_err_d)        led_alert_d = 1'b1;
    else if (clr_alert_i) led_alert_d = 1'b0;

    if (data_valid_i && (state_q != ST_IDLE)) overrun_d = 1'b1;
    else if (clr_alert_i)                     overrun_d = 1'b0;

    if (state_q == ST_WRITE) begin
      if (word_q[14])   wr_addr_d = ADDR_INIT;
      else if (wr_en_q) wr_addr_d = {ADDR_INIT[4], wr_addr_q[3:0] + 4'd1};
    end

    in_ready_d = (state_d == ST_IDLE);
  end

  assign in_ready_o   = in_ready_q;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = word_q;
  assign crc_err_o    = crc_err_q;
  assign frame_done_o = frame_done_q;
  assign err_cnt_o    = err_cnt_q;
  assign led_alert_o  = led_alert_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_rx_crc_checker.sv
// tb/tb_rx_crc_checker.sv - bench for rx_crc_checker, lanes a and b driven in parallel
// A timestamp-based model predicts every output each cycle; directed checks pin the model.
module tb_rx_crc_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] datain = 16'h0;
  logic        dv = 1'b0;
  logic        clr = 1'b0;
  logic        chk_en = 1'b0;

  int tests = 0;
  int fails = 0;

  logic        in_ready_a, wr_en_a, crc_err_a, frame_done_a, led_a, overrun_a;
  logic [4:0]  wr_addr_a;
  logic [15:0] wr_data_a;
  logic [7:0]  err_cnt_a;
  logic        in_ready_b, wr_en_b, crc_err_b, frame_done_b, led_b, overrun_b;
  logic [4:0]  wr_addr_b;
  logic [15:0] wr_data_b;
  logic [7:0]  err_cnt_b;

  always #5 clk = ~clk;

  rx_crc_checker #(.ADDR_INIT(5'b00000)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .datain_i(datain), .data_valid_i(dv), .clr_alert_i(clr),
    .in_ready_o(in_ready_a), .wr_en_o(wr_en_a), .wr_addr_o(wr_addr_a), .wr_data_o(wr_data_a),
    .crc_err_o(crc_err_a), .frame_done_o(frame_done_a), .err_cnt_o(err_cnt_a),
    .led_alert_o(led_a), .overrun_o(overrun_a)
  );

  rx_crc_checker #(.ADDR_INIT(5'b10000)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .datain_i(datain), .data_valid_i(dv), .clr_alert_i(clr),
    .in_ready_o(in_ready_b), .wr_en_o(wr_en_b), .wr_addr_o(wr_addr_b), .wr_data_o(wr_data_b),
    .crc_err_o(crc_err_b), .frame_done_o(frame_done_b), .err_cnt_o(err_cnt_b),
    .led_alert_o(led_b), .overrun_o(overrun_b)
  );

  // Polynomial long division of the 14-bit codeword by x^4+x^2+x+1.
  function automatic logic [3:0] crc_rem(input logic [13:0] cw);
    logic [13:0] r;
    logic [13:0] g;
    r = cw;
    for (int i = 13; i >= 4; i--) begin
      if (r[i]) begin
        g = 14'h0017 << (i - 4);
        r = r ^ g;
      end
    end
    return r[3:0];
  endfunction

  task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: times everything from the edge index at which a word was accepted.
  int          e_idx = 0;
  int          acc = 0;
  logic        pend = 1'b0;
  logic [15:0] m_word = 16'h0;
  logic        e_in_ready = 1'b1, e_wr_en = 1'b0, e_crc_err = 1'b0, e_frame_done = 1'b0;
  logic        e_led = 1'b0, e_ovr = 1'b0;
  logic [3:0]  e_addr = 4'h0;
  logic [7:0]  e_err_cnt = 8'h0;

  always @(posedge clk or negedge rst_n) begin : model
    logic fire, busy, pass, acc_now;
    if (!rst_n) begin
      e_idx <= 0; acc <= 0; pend <= 1'b0; m_word <= 16'h0;
      e_in_ready <= 1'b1; e_wr_en <= 1'b0; e_crc_err <= 1'b0; e_frame_done <= 1'b0;
      e_led <= 1'b0; e_ovr <= 1'b0; e_addr <= 4'h0; e_err_cnt <= 8'h0;
    end else begin
      fire    = pend && (e_idx + 1 == acc + 10);
      busy    = pend && (e_idx + 1 <= acc + 11);
      pass    = (crc_rem(m_word[13:0]) == 4'h0);
      acc_now = dv && !busy && datain[15];
      e_idx        <= e_idx + 1;
      e_wr_en      <= fire && pass;
      e_crc_err    <= fire && !pass;
      e_frame_done <= fire && m_word[14];
      if (fire && !pass && e_err_cnt != 8'hFF) e_err_cnt <= e_err_cnt + 8'd1;
      if (fire && !pass) e_led <= 1'b1;
      else if (clr)      e_led <= 1'b0;
      if (dv && busy) e_ovr <= 1'b1;
      else if (clr)   e_ovr <= 1'b0;
      if (pend && (e_idx + 1 == acc + 11)) begin
        if (m_word[14]) e_addr <= 4'h0;
        else if (pass)  e_addr <= e_addr + 4'd1;
        pend <= 1'b0;
      end
      if (acc_now) begin
        pend   <= 1'b1;
        acc    <= e_idx + 1;
        m_word <= datain;
      end
      e_in_ready <= !(acc_now || (pend && (e_idx + 1 <= acc + 10)));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cycle_lane_a",
          {in_ready_a, wr_en_a, wr_addr_a, wr_data_a, crc_err_a, frame_done_a, err_cnt_a, led_a, overrun_a},
          {e_in_ready, e_wr_en, {1'b0, e_addr}, m_word, e_crc_err, e_frame_done, e_err_cnt, e_led, e_ovr});
      chk("cycle_lane_b",
          {in_ready_b, wr_en_b, wr_addr_b, wr_data_b, crc_err_b, frame_done_b, err_cnt_b, led_b, overrun_b},
          {e_in_ready, e_wr_en, {1'b1, e_addr}, m_word, e_crc_err, e_frame_done, e_err_cnt, e_led, e_ovr});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [15:0] w);
    @(negedge clk); datain = w; dv = 1'b1;
    @(negedge clk); dv = 1'b0;
  endtask

  task automatic send(input logic [15:0] w);
    strobe(w);
    tick(11);
  endtask

  initial begin : stim
    logic seen;
    tick(3);
    chk_en = 1'b1;
    chk("rst_in_ready", 35'(in_ready_a), 35'd1);
    chk("rst_wr_en", 35'(wr_en_a), 35'd0);
    chk("rst_addr_a", 35'(wr_addr_a), 35'h00);
    chk("rst_addr_b", 35'(wr_addr_b), 35'h10);
    chk("rst_flags", 35'({err_cnt_a, led_a, overrun_a, crc_err_a, frame_done_a}), 35'd0);
    chk("model_rem_good", 35'(crc_rem(14'h0017)), 35'h0);
    chk("model_rem_bad", 35'(crc_rem(14'h0016)), 35'h1);
    @(negedge clk); #2 rst_n = 1'b1;
    tick(2);

    // good word
    strobe(16'h8017); tick(10);
    chk("good_wr_en", 35'({wr_en_a, crc_err_a}), 35'b10);
    chk("good_addr", 35'(wr_addr_a), 35'h00);
    chk("good_data", 35'(wr_data_a), 35'h8017);
    tick(1);
    chk("good_addr_next", 35'({in_ready_a, wr_addr_a}), 35'({1'b1, 5'h01}));

    // bad word, then clear
    strobe(16'h8016); tick(10);
    chk("bad_pulse", 35'({wr_en_a, crc_err_a}), 35'b01);
    tick(1);
    chk("bad_status", 35'({err_cnt_a, led_a}), 35'({8'd1, 1'b1}));
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("clr_status", 35'({err_cnt_a, led_a}), 35'({8'd1, 1'b0}));

    // filler ignored
    strobe(16'h0017);
    chk("filler_ready", 35'(in_ready_a), 35'd1);
    tick(3);
    chk("filler_addr", 35'({in_ready_a, wr_addr_a}), 35'({1'b1, 5'h01}));

    // overrun with simultaneous clr: overrun wins, first word still written
    strobe(16'h8017); tick(3);
    @(negedge clk); datain = 16'h8016; dv = 1'b1; clr = 1'b1;
    @(negedge clk); dv = 1'b0; clr = 1'b0;
    chk("overrun_set", 35'(overrun_a), 35'd1);
    tick(5);
    chk("overrun_write", 35'({wr_en_a, wr_data_a, wr_addr_a}), 35'({1'b1, 16'h8017, 5'h01}));
    tick(1);

    // clr and CRC failure in the same cycle
    strobe(16'h8016); tick(8);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("clr_vs_fail", 35'({crc_err_a, led_a}), 35'b11);
    tick(1);

    // reset mid-DIVIDE
    strobe(16'h8017); tick(4);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 chk("midrst_outputs", 35'({in_ready_a, wr_en_a, wr_addr_a, wr_addr_b, err_cnt_a, led_a, overrun_a}),
           35'({1'b1, 1'b0, 5'h00, 5'h10, 8'd0, 1'b0, 1'b0}));
    tick(2); #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); seen = seen | wr_en_a | wr_en_b;
    end
    chk("midrst_no_write", 35'(seen), 35'd0);

    // lane b wrap then end-of-frame
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send(16'h8017);
      seen = seen | ~wr_addr_b[4];
    end
    chk("wrap_addr_b", 35'({seen, wr_addr_b}), 35'h10);
    send(16'h8017);
    chk("wrap_addr_b17", 35'(wr_addr_b), 35'h11);
    strobe(16'hC017); tick(10);
    chk("frame_write", 35'({wr_en_a, frame_done_a, wr_addr_b, wr_data_b}), 35'({2'b11, 5'h11, 16'hC017}));
    tick(1);
    chk("frame_addr_ret", 35'({wr_addr_a, wr_addr_b}), 35'({5'h00, 5'h10}));

    // end-of-frame on a failing word also returns the address
    send(16'h8017);
    strobe(16'hC016); tick(10);
    chk("frame_bad", 35'({wr_en_a, crc_err_a, frame_done_a}), 35'b011);
    tick(1);
    chk("frame_bad_addr", 35'(wr_addr_b), 35'h10);

    // saturation
    for (int i = 0; i < 300; i++) send(16'h8016);
    chk("saturate", 35'({err_cnt_a, err_cnt_b, led_a}), 35'({8'd255, 8'd255, 1'b1}));

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
